// File: rtl/noise_gate.sv
// noise_gate: first effect stage of the guitar chain. Tracks a peak envelope of the
// incoming samples and gates the signal through a five-state gain machine
// (closed -> opening -> open -> hold -> closing). The 3-bit level picks the open
// threshold; level 0 or i_en=0 passes samples straight through.
//
// Ports:
//   i_AUD_BCLK   clock
//   i_rst_n      asynchronous active-low reset
//   i_en         1 = gate active, 0 = bypass
//   i_level      threshold select (T = 64 << (level-1)); 0 = bypass
//   i_valid      one-cycle strobe qualifying i_sample
//   i_sample     signed input sample
//   o_valid      one-cycle strobe, asserted exactly one cycle after i_valid
//   o_sample     signed gated sample, held between strobes
//   o_gate_open  high while the gate is opening, open or holding
module noise_gate #(
  parameter int unsigned DW           = 16,
  parameter int unsigned HOLD_SAMPLES = 2048,
  parameter int unsigned ENV_SHIFT    = 4,
  parameter int unsigned ATTACK_STEP  = 16
) (
  input  logic                 i_AUD_BCLK,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic [2:0]           i_level,
  input  logic                 i_valid,
  input  logic signed [DW-1:0] i_sample,
  output logic                 o_valid,
  output logic signed [DW-1:0] o_sample,
  output logic                 o_gate_open
);

  // Envelope / magnitude width: |sample| saturates to DW-1 bits.
  localparam int unsigned AW = DW - 1;
  // Gain is 0..256 where 256 is unity.
  localparam int unsigned GW = 9;
  // Product width: |sample| * 256 fits in DW+8 signed bits.
  localparam int unsigned PW = DW + 8;
  localparam int unsigned HW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;

  localparam logic [GW-1:0] GainUnity = GW'(256);
  localparam logic [GW-1:0] GainStep  = GW'(ATTACK_STEP);
  localparam logic [HW-1:0] HoldLast  = HW'(HOLD_SAMPLES - 1);
  localparam logic [DW-1:0] SampleMin = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    StClosed,
    StOpening,
    StOpen,
    StHold,
    StClosing
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] env_q, env_d;
  logic [GW-1:0] gain_q, gain_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [AW-1:0]        abs_sample;
  logic [AW-1:0]        thr_open;
  logic [AW-1:0]        thr_close;
  logic                 open_hit;
  logic                 close_hit;
  logic                 bypass;
  logic [GW:0]          gain_sum;
  logic [GW-1:0]        gain_up;
  logic signed [DW-1:0] gated;

  // Magnitude of the input; the most negative code saturates to full scale.
  always_comb begin
    if (i_sample == SampleMin) begin
      abs_sample = {AW{1'b1}};
    end else begin
      abs_sample = AW'(i_sample[DW-1] ? -i_sample : i_sample);
    end
  end

  // Peak envelope: instant attack, exponential decay on quieter samples.
  always_comb begin
    if (abs_sample > env_q) begin
      env_d = abs_sample;
    end else begin
      env_d = env_q - (env_q >> ENV_SHIFT);
    end
  end

  // Thresholds and comparisons, all on the updated envelope.
  always_comb begin
    thr_open  = AW'(32'd64) << (i_level - 3'd1);
    thr_close = thr_open >> 1;
    open_hit  = (env_d >= thr_open);
    close_hit = (env_d < thr_close);
    bypass    = !i_en || (i_level == 3'd0);
  end

  // Attack increment, clamped at unity.
  always_comb begin
    gain_sum = {1'b0, gain_q} + {1'b0, GainStep};
    if (gain_sum >= {1'b0, GainUnity}) begin
      gain_up = GainUnity;
    end else begin
      gain_up = gain_sum[GW-1:0];
    end
  end

  // Signed sample times unsigned gain, arithmetic shift by 8 (floor). Uses the gain
  // in effect before this sample's update.
  always_comb begin
    gated = DW'((PW'(i_sample) * PW'($signed({1'b0, gain_q}))) >>> 8);
  end

  // Gain state machine next-state logic.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    hold_d  = hold_q;
    if (bypass) begin
      state_d = StOpen;
      gain_d  = GainUnity;
    end else begin
      unique case (state_q)
        StClosed: begin
          if (open_hit) begin
            state_d = StOpening;
            gain_d  = GainStep;
          end
        end
        StOpening: begin
          gain_d = gain_up;
          if (gain_up == GainUnity) begin
            state_d = StOpen;
          end
        end
        StOpen: begin
          // Inside the hysteresis band nothing changes.
          if (close_hit) begin
            state_d = StHold;
            hold_d  = '0;
          end
        end
        StHold: begin
          if (open_hit) begin
            state_d = StOpen;
          end else if (hold_q == HoldLast) begin
            state_d = StClosing;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        StClosing: begin
          // A loud sample retriggers the attack from the current gain.
          if (open_hit) begin
            state_d = StOpening;
            gain_d  = gain_up;
          end else if (gain_q <= GW'(1)) begin
            state_d = StClosed;
            gain_d  = '0;
          end else begin
            gain_d = gain_q - GW'(1);
          end
        end
        default: begin
          state_d = StClosed;
          gain_d  = '0;
        end
      endcase
    end
  end

  // State and registered outputs; everything advances only on valid samples.
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StClosed;
      env_q       <= '0;
      gain_q      <= '0;
      hold_q      <= '0;
      o_valid     <= 1'b0;
      o_sample    <= '0;
      o_gate_open <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        state_q     <= state_d;
        env_q       <= env_d;
        gain_q      <= gain_d;
        hold_q      <= hold_d;
        o_sample    <= bypass ? i_sample : gated;
        o_gate_open <= (state_d == StOpening) || (state_d == StOpen) || (state_d == StHold);
      end
    end
  end

endmodule

// File: tb/tb_noise_gate.sv
// Scoreboard bench for noise_gate: stimulus pushes expected outputs from a
// behavioural model, a monitor pops and compares on every o_valid.
module tb_noise_gate;

  localparam int DW        = 16;
  localparam int Hold      = 16;
  localparam int MaxCycles = 60000;

  localparam int MClosed   = 0;
  localparam int MOpening  = 1;
  localparam int MOpen     = 2;
  localparam int MHold     = 3;
  localparam int MClosing  = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic [2:0]           level = 3'd0;
  logic                 valid = 1'b0;
  logic signed [DW-1:0] sample = '0;
  logic                 o_valid;
  logic signed [DW-1:0] o_sample;
  logic                 o_gate_open;

  noise_gate #(
    .DW           (DW),
    .HOLD_SAMPLES (Hold),
    .ENV_SHIFT    (4),
    .ATTACK_STEP  (16)
  ) dut (
    .i_AUD_BCLK  (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_level     (level),
    .i_valid     (valid),
    .i_sample    (sample),
    .o_valid     (o_valid),
    .o_sample    (o_sample),
    .o_gate_open (o_gate_open)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int s;
    bit open;
    int issue;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   last_s = 0;
  bit   cur_en = 1'b1;
  int   cur_lvl = 0;

  // Behavioural model state.
  int m_env, m_gain, m_state, m_hold;

  task automatic check(input string name, input bit ok, input int got, input int want);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, got, want);
  endtask

  function automatic void model_reset();
    m_env   = 0;
    m_gain  = 0;
    m_state = MClosed;
    m_hold  = 0;
  endfunction

  task automatic model_step(input int s, input bit en_v, input int lvl,
                            output int y, output bit open);
    int a, env_n, thr, p;
    a = (s < 0) ? -s : s;
    if (a > 32767) a = 32767;
    env_n = (a > m_env) ? a : m_env - m_env / 16;
    m_env = env_n;
    if (!en_v || lvl == 0) begin
      y       = s;
      m_state = MOpen;
      m_gain  = 256;
      open    = 1'b1;
      return;
    end
    p = s * m_gain;
    y = (p >= 0) ? p / 256 : -((-p + 255) / 256);
    thr = 64 * (1 << (lvl - 1));
    case (m_state)
      MClosed: if (env_n >= thr) begin m_state = MOpening; m_gain = 16; end
      MOpening: begin
        m_gain = (m_gain + 16 > 256) ? 256 : m_gain + 16;
        if (m_gain == 256) m_state = MOpen;
      end
      MOpen: if (env_n < thr / 2) begin m_state = MHold; m_hold = 0; end
      MHold: begin
        if (env_n >= thr) m_state = MOpen;
        else if (m_hold == Hold - 1) m_state = MClosing;
        else m_hold++;
      end
      default: begin
        if (env_n >= thr) begin
          m_state = MOpening;
          m_gain  = (m_gain + 16 > 256) ? 256 : m_gain + 16;
        end else begin
          m_gain--;
          if (m_gain == 0) m_state = MClosed;
        end
      end
    endcase
    open = (m_state == MOpening) || (m_state == MOpen) || (m_state == MHold);
  endtask

  task automatic send(input int s);
    int y;
    bit op;
    @(negedge clk);
    valid  = 1'b1;
    sample = 16'(s);
    en     = cur_en;
    level  = 3'(cur_lvl);
    model_step(s, cur_en, cur_lvl, y, op);
    sb.push_back('{y, op, cycle});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
    end
  endtask

  // Asynchronous reset between clock edges; any in-flight output is discarded.
  task automatic reset_pulse();
    @(posedge clk);
    #2;
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_o_valid", o_valid == 1'b0, int'(o_valid), 0);
    check("rst_o_sample", o_sample == 0, int'(o_sample), 0);
    check("rst_o_gate_open", o_gate_open == 1'b0, int'(o_gate_open), 0);
    sb.delete();
    model_reset();
    last_s = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every presented output against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && o_valid) begin
        if (sb.size() == 0) begin
          check("spurious_o_valid", 1'b0, 1, 0);
        end else begin
          e = sb.pop_front();
          check("o_sample", o_sample == e.s, int'(o_sample), e.s);
          check("o_gate_open", o_gate_open == e.open, int'(o_gate_open), int'(e.open));
          check("latency", cycle == e.issue + 1, cycle - e.issue, 1);
          last_s = e.s;
        end
      end else if (rst_n) begin
        check("o_sample_held", o_sample == last_s, int'(o_sample), last_s);
      end
    end
  end

  initial begin
    #(MaxCycles * 10);
    $display("FAIL watchdog: cycle %0d exceeded budget %0d", cycle, MaxCycles);
    $fatal(1);
  end

  initial begin
    int amps[8];
    int n;
    amps = '{0, 20, 50, 150, 400, 1500, 8000, 32767};
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_o_valid", o_valid == 1'b0, int'(o_valid), 0);
    check("reset_o_sample", o_sample == 0, int'(o_sample), 0);
    check("reset_o_gate_open", o_gate_open == 1'b0, int'(o_gate_open), 0);
    rst_n = 1'b1;

    // Bypass by level 0, then by i_en=0.
    cur_en = 1'b1; cur_lvl = 0;
    repeat (4) send(1000);
    send(-32768);
    idle(2);
    cur_en = 1'b0; cur_lvl = 3;
    for (int i = 0; i < 6; i++) send(int'($urandom_range(0, 4000)) - 2000);
    idle(2);

    // Opening ramp at T=64.
    cur_en = 1'b1; cur_lvl = 1;
    reset_pulse();
    repeat (8) send(0);
    repeat (20) send(1000);

    // Decay into hold, closing, closed.
    repeat (360) send(0);
    idle(2);
    check("closed_after_release", m_state == MClosed && o_gate_open == 1'b0,
          int'(o_gate_open), 0);

    // Retrigger while closing at gain 100.
    repeat (20) send(1000);
    n = 0;
    while (!(m_state == MClosing && m_gain == 100) && n < 1000) begin
      send(0);
      n++;
    end
    check("reach_closing_gain_100", n < 1000, n, 1000);
    repeat (20) send(1000);
    idle(1);

    // Hysteresis at T=256: 200 keeps the gate open, 100 releases it.
    cur_lvl = 3;
    repeat (20) send(1000);
    repeat (150) begin
      send(200);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    repeat (80) send(100);
    idle(2);

    // Async reset mid-opening, then restart from gain 0.
    cur_lvl = 1;
    repeat (5) send(0);
    repeat (5) send(1000);
    reset_pulse();
    repeat (4) send(1000);
    idle(2);

    // Randomised bursts with changing level, enable and gaps.
    for (int b = 0; b < 40; b++) begin
      int amp, len;
      amp     = amps[$urandom_range(0, 7)];
      len     = $urandom_range(5, 80);
      cur_lvl = $urandom_range(0, 7);
      cur_en  = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < len; i++) begin
        int s;
        s = int'($urandom_range(0, 2 * amp)) - amp;
        if (amp == 32767 && $urandom_range(0, 20) == 0) s = -32768;
        send(s);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      if (b == 20) begin
        idle(1);
        reset_pulse();
      end
    end

    idle(4);
    check("scoreboard_drained", sb.size() == 0, sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
